// File: rtl/dma_channel_scheduler.sv
// Round-robin scheduler sharing one byte-copy DMA engine among NUM_CH requesters.
// Programs the engine over its Avalon-MM config slave, polls status, then reports completion.
module dma_channel_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_S     = 0,
    parameter int ADDR_D     = 1,
    parameter int ADDR_LEN   = 2,
    parameter int ADDR_START = 3,
    parameter int ADDR_STAT  = 4,
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    req,
    input  logic [32*NUM_CH-1:0] src_addr,
    input  logic [32*NUM_CH-1:0] dst_addr,
    input  logic [32*NUM_CH-1:0] length,
    output logic [NUM_CH-1:0]    ack,
    output logic [NUM_CH-1:0]    done,
    output logic                 err,
    output logic                 busy,
    output logic [2:0]           avm_cfg_address,
    output logic                 avm_cfg_chipselect,
    output logic                 avm_cfg_read,
    output logic                 avm_cfg_write,
    output logic [31:0]          avm_cfg_writedata,
    input  logic [31:0]          avm_cfg_readdata,
    input  logic                 avm_cfg_waitrequest
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W  = $clog2(POLL_GAP + 1);
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_S, S_WR_D, S_WR_LEN, S_WR_START, S_GAP, S_POLL, S_COMPLETE
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [CH_W-1:0]     g_q, g_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic                err_q, err_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [31:0]         len_q, len_d;

    logic                grant_found;
    logic [CH_W-1:0]     grant_idx;
    logic [31:0]         grant_src, grant_dst, grant_len;
    logic [POLL_W-1:0]   poll_next;
    logic                unused_readdata;

    assign unused_readdata = ^avm_cfg_readdata[31:1];
    assign poll_next       = poll_q + POLL_W'(1);

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // First pending request at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_found && req[wrap_add(rr_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_q, i);
            end
        end
        grant_src = src_addr[32*grant_idx +: 32];
        grant_dst = dst_addr[32*grant_idx +: 32];
        grant_len = length[32*grant_idx +: 32];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            gap_q   <= '0;
            poll_q  <= '0;
            err_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            gap_q   <= gap_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        src_q <= src_d;
        dst_q <= dst_d;
        len_q <= len_d;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        gap_d   = gap_q;
        poll_d  = poll_q;
        err_d   = err_q;
        ack_d   = '0;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    ack_d  = NUM_CH'(1) << grant_idx;
                    g_d    = grant_idx;
                    rr_d   = wrap_add(grant_idx, 1);
                    poll_d = '0;
                    src_d  = grant_src;
                    dst_d  = grant_dst;
                    len_d  = grant_len;
                    // A zero-length copy never touches the engine.
                    if (grant_len == 32'd0) begin
                        err_d   = 1'b1;
                        state_d = S_COMPLETE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_WR_S;
                    end
                end
            end
            S_WR_S:     if (!avm_cfg_waitrequest) state_d = S_WR_D;
            S_WR_D:     if (!avm_cfg_waitrequest) state_d = S_WR_LEN;
            S_WR_LEN:   if (!avm_cfg_waitrequest) state_d = S_WR_START;
            S_WR_START: begin
                if (!avm_cfg_waitrequest) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_POLL;
                else                               gap_d   = gap_q + GAP_W'(1);
            end
            S_POLL: begin
                if (!avm_cfg_waitrequest) begin
                    if (avm_cfg_readdata[0]) begin
                        err_d   = 1'b0;
                        state_d = S_COMPLETE;
                    end else if (poll_next == POLL_W'(POLL_LIMIT)) begin
                        err_d   = 1'b1;
                        state_d = S_COMPLETE;
                    end else begin
                        poll_d  = poll_next;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        avm_cfg_address    = '0;
        avm_cfg_chipselect = 1'b0;
        avm_cfg_read       = 1'b0;
        avm_cfg_write      = 1'b0;
        avm_cfg_writedata  = '0;
        done               = '0;
        err                = 1'b0;
        ack                = ack_q;
        busy               = (state_q != S_IDLE) && (state_q != S_COMPLETE);
        case (state_q)
            S_WR_S: begin
                avm_cfg_chipselect = 1'b1;
                avm_cfg_write      = 1'b1;
                avm_cfg_address    = 3'(ADDR_S);
                avm_cfg_writedata  = src_q;
            end
            S_WR_D: begin
                avm_cfg_chipselect = 1'b1;
                avm_cfg_write      = 1'b1;
                avm_cfg_address    = 3'(ADDR_D);
                avm_cfg_writedata  = dst_q;
            end
            S_WR_LEN: begin
                avm_cfg_chipselect = 1'b1;
                avm_cfg_write      = 1'b1;
                avm_cfg_address    = 3'(ADDR_LEN);
                avm_cfg_writedata  = len_q;
            end
            S_WR_START: begin
                avm_cfg_chipselect = 1'b1;
                avm_cfg_write      = 1'b1;
                avm_cfg_address    = 3'(ADDR_START);
                avm_cfg_writedata  = 32'd1;
            end
            S_POLL: begin
                avm_cfg_chipselect = 1'b1;
                avm_cfg_read       = 1'b1;
                avm_cfg_address    = 3'(ADDR_STAT);
            end
            S_COMPLETE: begin
                done = NUM_CH'(1) << g_q;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed bench for dma_channel_scheduler with a small engine model (stall and status control)
// and a bus monitor logging accepted accesses, acks and completions.
module tb_dma_channel_scheduler;

    localparam int NUM_CH     = 4;
    localparam int POLL_GAP   = 4;
    localparam int POLL_LIMIT = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] src_addr = '0, dst_addr = '0, length = '0;
    logic [3:0]   ack, done;
    logic         err, busy;
    logic [2:0]   addr;
    logic         cs, rd, wr;
    logic [31:0]  wdata, rdata;
    logic         waitreq;

    int n_checks = 0, n_errors = 0;
    int stall_n = 0, done_at = 1, stall_left = 0, reads_tx = 0;

    logic [2:0]  wr_addr [256];
    logic [31:0] wr_data [256];
    logic [2:0]  rd_addr [256];
    int          rd_t    [256];
    int          ack_log [256];
    int wr_n = 0, rd_n = 0, ack_n = 0, done_cnt = 0, strobe_cnt = 0, viol = 0, cyc = 0;
    logic [3:0]  last_done = '0;
    logic        last_err = 1'b0;
    logic        held = 1'b0;
    logic [37:0] held_v = '0;
    logic [37:0] bus_now;
    int ab, db, wb, rb, sb;

    dma_channel_scheduler #(
        .NUM_CH(NUM_CH), .ADDR_S(0), .ADDR_D(1), .ADDR_LEN(2), .ADDR_START(3), .ADDR_STAT(4),
        .POLL_GAP(POLL_GAP), .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .ack(ack), .done(done), .err(err), .busy(busy),
        .avm_cfg_address(addr), .avm_cfg_chipselect(cs), .avm_cfg_read(rd),
        .avm_cfg_write(wr), .avm_cfg_writedata(wdata), .avm_cfg_readdata(rdata),
        .avm_cfg_waitrequest(waitreq)
    );

    always #5 clk = ~clk;

    assign waitreq = cs && (stall_left != 0);
    assign rdata   = (done_at != 0 && reads_tx + 1 >= done_at) ? 32'h1 : 32'h0;
    assign bus_now = {cs, rd, wr, addr, wdata};

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!cs)                  stall_left <= stall_n;
        else if (stall_left != 0) stall_left <= stall_left - 1;
        else                      stall_left <= stall_n;
        if (cs && wr && !waitreq) begin
            wr_addr[wr_n] <= addr;
            wr_data[wr_n] <= wdata;
            wr_n <= wr_n + 1;
            if (addr == 3'd3) reads_tx <= 0;
        end
        if (cs && rd && !waitreq) begin
            rd_addr[rd_n] <= addr;
            rd_t[rd_n]    <= cyc;
            rd_n          <= rd_n + 1;
            reads_tx      <= reads_tx + 1;
        end
        if (cs) strobe_cnt <= strobe_cnt + 1;
        if (ack != 0) begin
            ack_log[ack_n] <= onehot_idx(ack);
            ack_n <= ack_n + 1;
        end
        if (done != 0) begin
            done_cnt  <= done_cnt + 1;
            last_done <= done;
            last_err  <= err;
        end
        viol   <= viol + ((rd && wr) ? 1 : 0) + ((held && bus_now != held_v) ? 1 : 0);
        held   <= cs && waitreq;
        held_v <= bus_now;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        ab = ack_n; db = done_cnt; wb = wr_n; rb = rd_n; sb = strobe_cnt;
    endtask

    task automatic do_req(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        src_addr[32*ch +: 32] = s;
        dst_addr[32*ch +: 32] = d;
        length[32*ch +: 32]   = l;
        snap();
        req[ch] = 1'b1;
        for (int k = 0; k < 40 && ack_n == ab; k++) @(negedge clk);
        req[ch] = 1'b0;
        check("ack_count", 64'(ack_n - ab), 64'd1);
        check("ack_chan", 64'(ack_log[ab]), 64'(ch));
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int k = 0; k < budget && done_cnt - db < n; k++) @(negedge clk);
        check("done_count", 64'(done_cnt - db), 64'(n));
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int exp_order [8];
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err_busy", 64'({err, busy}), 64'd0);
        check("rst_bus", 64'({cs, rd, wr}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single transfer on ch1, status done on first read
        stall_n = 0; done_at = 1;
        do_req(1, 32'h100, 32'h200, 32'd8);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done(1, 200);
        check("t1_wr_n", 64'(wr_n - wb), 64'd4);
        for (int i = 0; i < 4; i++) check("t1_wr_addr", 64'(wr_addr[wb+i]), 64'(i));
        check("t1_wr_src", 64'(wr_data[wb]), 64'h100);
        check("t1_wr_dst", 64'(wr_data[wb+1]), 64'h200);
        check("t1_wr_len", 64'(wr_data[wb+2]), 64'd8);
        check("t1_rd_n", 64'(rd_n - rb), 64'd1);
        check("t1_rd_addr", 64'(rd_addr[rb]), 64'd4);
        check("t1_done", 64'(last_done), 64'b0010);
        check("t1_err", 64'(last_err), 64'd0);
        @(negedge clk);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Round-robin with all channels requesting, then ch0 withdrawn
        apply_reset();
        snap();
        req = 4'b1111;
        for (int k = 0; k < 1000 && ack_n - ab < 5; k++) @(negedge clk);
        req[0] = 1'b0;
        for (int k = 0; k < 1000 && ack_n - ab < 8; k++) @(negedge clk);
        req = '0;
        wait_done(8, 1000);
        check("t2_ack_n", 64'(ack_n - ab), 64'd8);
        for (int i = 0; i < 8; i++) check("t2_order", 64'(ack_log[ab+i]), 64'(exp_order[i]));

        // Three stall cycles on every access, done on second status read
        stall_n = 3; done_at = 2;
        do_req(0, 32'hA0, 32'hB0, 32'h10);
        wait_done(1, 400);
        stall_n = 0;
        check("t3_wr_n", 64'(wr_n - wb), 64'd4);
        for (int i = 0; i < 4; i++) check("t3_wr_addr", 64'(wr_addr[wb+i]), 64'(i));
        check("t3_wr_src", 64'(wr_data[wb]), 64'hA0);
        check("t3_wr_dst", 64'(wr_data[wb+1]), 64'hB0);
        check("t3_wr_len", 64'(wr_data[wb+2]), 64'h10);
        check("t3_rd_n", 64'(rd_n - rb), 64'd2);
        check("t3_strobe_cycles", 64'(strobe_cnt - sb), 64'd24);
        check("t3_done", 64'(last_done), 64'b0001);
        check("t3_err", 64'(last_err), 64'd0);

        // Zero length on ch2
        done_at = 1;
        do_req(2, 32'h300, 32'h400, 32'd0);
        wait_done(1, 50);
        check("t4_done", 64'(last_done), 64'b0100);
        check("t4_err", 64'(last_err), 64'd1);
        check("t4_strobes", 64'(strobe_cnt - sb), 64'd0);

        // Status never done: POLL_LIMIT reads spaced by POLL_GAP idle cycles
        done_at = 0;
        do_req(3, 32'h500, 32'h600, 32'd4);
        wait_done(1, 300);
        check("t5_rd_n", 64'(rd_n - rb), 64'd3);
        check("t5_rd_addr", 64'(rd_addr[rb+2]), 64'd4);
        check("t5_gap1", 64'(rd_t[rb+1] - rd_t[rb]), 64'(POLL_GAP + 1));
        check("t5_gap2", 64'(rd_t[rb+2] - rd_t[rb+1]), 64'(POLL_GAP + 1));
        check("t5_done", 64'(last_done), 64'b1000);
        check("t5_err", 64'(last_err), 64'd1);

        // Reset during POLL, then a fresh request
        do_req(1, 32'h700, 32'h800, 32'd8);
        for (int k = 0; k < 50 && !rd; k++) @(negedge clk);
        check("t6_in_poll", 64'(rd), 64'd1);
        db = done_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_rst_outs", 64'({ack, done, err, busy, cs, rd, wr}), 64'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_done", 64'(done_cnt - db), 64'd0);
        done_at = 1;
        do_req(2, 32'h900, 32'hA00, 32'h20);
        wait_done(1, 200);
        check("t6_wr_n", 64'(wr_n - wb), 64'd4);
        check("t6_wr_src", 64'(wr_data[wb]), 64'h900);
        check("t6_done", 64'(last_done), 64'b0100);
        check("t6_err", 64'(last_err), 64'd0);

        check("protocol_violations", 64'(viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
